// File: rtl/alu_slice_seq.sv
// Multi-cycle 68k-style integer ALU. It pushes WORD-bit slices through one shared adder/logic
// slice, least significant slice first, and produces C/V/Z/N/X from the top active slice.
module alu_slice_seq #(
  parameter  int WORD   = 16,
  parameter  int SLICES = 2,
  localparam int LW     = (SLICES > 1) ? $clog2(SLICES) : 1,
  localparam int DW     = WORD * SLICES
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic          x_in,
  input  logic          z_in,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] O,
  output logic          C,
  output logic          V,
  output logic          Z,
  output logic          N,
  output logic          X
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDX = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_SUBX = 3'd3;
  localparam logic [2:0] OP_CMP  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_EOR  = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state, state_nx;
  logic [2:0]    op_q;
  logic [LW-1:0] len_q, len_c, k;
  logic [DW-1:0] a_q, b_q;
  logic          xin_q, zin_q;
  logic          carry, zacc;
  logic          accept;

  logic [WORD-1:0] a_k, b_k, s;
  logic [WORD:0]   sum;
  logic            is_sub, is_logic, is_ext, is_top;
  logic            next_carry, z_all;
  logic            c_f, v_f, z_f, x_f;

  // Out-of-range lengths are treated as the widest legal operation.
  assign len_c  = (int'(len) > SLICES - 1) ? LW'(SLICES - 1) : len;
  assign accept = start && (state != RUN);

  // Slice datapath. For subtracts, carry holds the running borrow.
  // NOTE: every signal written in a combinational block gets a value on every path, so no latch is inferred.
  always_comb begin
    a_k        = a_q[int'(k)*WORD +: WORD];
    b_k        = b_q[int'(k)*WORD +: WORD];
    is_sub     = (op_q == OP_SUB) || (op_q == OP_SUBX) || (op_q == OP_CMP);
    is_logic   = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_EOR);
    is_ext     = (op_q == OP_ADDX) || (op_q == OP_SUBX);
    is_top     = (k == len_q);
    sum        = {1'b0, b_k} + {1'b0, (is_sub ? ~a_k : a_k)}
               + {{WORD{1'b0}}, (is_sub ? ~carry : carry)};
    next_carry = is_sub ? ~sum[WORD] : sum[WORD];
    case (op_q)
      OP_AND:  s = a_k & b_k;
      OP_OR:   s = a_k | b_k;
      OP_EOR:  s = a_k ^ b_k;
      default: s = sum[WORD-1:0];
    endcase
    z_all = zacc && (s == '0);
    c_f   = is_logic ? 1'b0 : next_carry;
    if (is_logic)
      v_f = 1'b0;
    else if (is_sub)
      v_f = (a_k[WORD-1] != b_k[WORD-1]) && (s[WORD-1] != b_k[WORD-1]);
    else
      v_f = (a_k[WORD-1] == b_k[WORD-1]) && (s[WORD-1] != a_k[WORD-1]);
    z_f = is_ext ? (zin_q && z_all) : z_all;
    x_f = (op_q <= OP_SUBX) ? c_f : xin_q;
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (is_top) state_nx = FIN;
      FIN:     state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == FIN);
  end

  // Operand capture, slice accumulation and flag update
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q  <= OP_ADD;
      len_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      xin_q <= 1'b0;
      zin_q <= 1'b0;
      k     <= '0;
      carry <= 1'b0;
      zacc  <= 1'b0;
      O     <= '0;
      C     <= 1'b0;
      V     <= 1'b0;
      Z     <= 1'b0;
      N     <= 1'b0;
      X     <= 1'b0;
    end else if (accept) begin
      op_q  <= op;
      len_q <= len_c;
      a_q   <= A;
      b_q   <= B;
      xin_q <= x_in;
      zin_q <= z_in;
      k     <= '0;
      carry <= ((op == OP_ADDX) || (op == OP_SUBX)) ? x_in : 1'b0;
      zacc  <= 1'b1;
      O     <= '0;
    end else if (state == RUN) begin
      if (op_q != OP_CMP) O[int'(k)*WORD +: WORD] <= s;
      carry <= next_carry;
      zacc  <= z_all;
      if (is_top) begin
        C <= c_f;
        V <= v_f;
        Z <= z_f;
        N <= s[WORD-1];
        X <= x_f;
      end else begin
        k <= k + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_slice_seq.sv
// Directed bench for alu_slice_seq (WORD=16, SLICES=2) with hand-computed results.
// Cycle index 0 is the cycle in which start is driven; done is expected in cycle len+2.
module tb_alu_slice_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic        len;
  logic [31:0] a, b;
  logic        x_in, z_in;
  logic        busy, done;
  logic [31:0] o;
  logic        c, v, z, n, x;

  int passed = 0;
  int total  = 0;

  alu_slice_seq #(.WORD(16), .SLICES(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .len(len),
    .A(a), .B(b), .x_in(x_in), .z_in(z_in), .busy(busy), .done(done),
    .O(o), .C(c), .V(v), .Z(z), .N(n), .X(x)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else passed++;
  endtask

  function automatic logic [4:0] flags();
    return {c, v, z, n, x};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one start pulse from the current cycle and waits for done.
  task automatic run_op(input string tag, input logic [2:0] op_i, input logic len_i,
                        input logic [31:0] a_i, input logic [31:0] b_i,
                        input logic x_i, input logic z_i);
    int lat;
    op = op_i; len = len_i; a = a_i; b = b_i; x_in = x_i; z_in = z_i;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, lat, len_i + 2);
  endtask

  initial begin
    int dones;
    int lat;
    logic [31:0] o_seen;
    reset_n = 1'b0; start = 1'b0; op = 3'd0; len = 1'b0;
    a = '0; b = '0; x_in = 1'b0; z_in = 1'b0;
    step(); step();
    check("rst_busy",  busy,    1'b0);
    check("rst_done",  done,    1'b0);
    check("rst_o",     o,       32'h0);
    check("rst_flags", flags(), 5'b00000);
    reset_n = 1'b1;
    step();

    // ADD one slice: carry out, zero result; upper operand slice ignored and O upper = 0
    run_op("add16", 3'd0, 1'b0, 32'h1234_FFFF, 32'h5678_0001, 1'b0, 1'b0);
    check("add16_o", o, 32'h0000_0000);
    check("add16_f", flags(), 5'b10101);
    step();
    check("add16_done_pulse", done, 1'b0);

    run_op("add32", 3'd0, 1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check("add32_o", o, 32'h0001_0000);
    check("add32_f", flags(), 5'b00000);

    run_op("addv", 3'd0, 1'b0, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0);
    check("addv_o", o, 32'h0000_8000);
    check("addv_f", flags(), 5'b01010);

    run_op("sub32", 3'd2, 1'b1, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0);
    check("sub32_o", o, 32'h7FFF_FFFF);
    check("sub32_f", flags(), 5'b01000);

    run_op("cmp32", 3'd4, 1'b1, 32'h0000_0002, 32'h0000_0001, 1'b1, 1'b0);
    check("cmp32_o", o, 32'h0);
    check("cmp32_f", flags(), 5'b10011);

    run_op("addx_z1", 3'd1, 1'b1, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1);
    check("addx_z1_o", o, 32'h0);
    check("addx_z1_f", flags(), 5'b10101);

    run_op("addx_z0", 3'd1, 1'b1, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("addx_z0_o", o, 32'h0);
    check("addx_z0_f", flags(), 5'b10001);

    run_op("and32", 3'd5, 1'b1, 32'hF0F0_FF00, 32'h0FF0_F0F0, 1'b0, 1'b0);
    check("and32_o", o, 32'h00F0_F000);
    check("and32_f", flags(), 5'b00000);

    run_op("or16", 3'd6, 1'b0, 32'h0000_8000, 32'h0000_0001, 1'b1, 1'b0);
    check("or16_o", o, 32'h0000_8001);
    check("or16_f", flags(), 5'b00011);

    run_op("eor32", 3'd7, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
    check("eor32_o", o, 32'h0);
    check("eor32_f", flags(), 5'b00100);

    run_op("subx16", 3'd3, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    check("subx16_o", o, 32'h0000_FFFF);
    check("subx16_f", flags(), 5'b10011);

    // start while busy is ignored
    step();
    op = 3'd0; len = 1'b1; a = 32'h1; b = 32'h2; start = 1'b1;
    step();
    start = 1'b1; len = 1'b0; a = 32'h10; b = 32'h10;
    step();
    start = 1'b0;
    dones = 0;
    o_seen = '0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin
        dones++;
        o_seen = o;
      end
      step();
    end
    check("busy_ign_dones", dones, 1);
    check("busy_ign_o", o_seen, 32'h3);

    // start during the FIN cycle is accepted
    run_op("b2b_first", 3'd0, 1'b1, 32'h5, 32'h6, 1'b0, 1'b0);
    check("b2b_first_o", o, 32'hB);
    op = 3'd2; len = 1'b0; a = 32'h1; b = 32'h3; start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    check("b2b_lat", lat, 2);
    check("b2b_o", o, 32'h2);
    check("b2b_f", flags(), 5'b00000);

    // Reset mid-RUN; flags and O are nonzero beforehand
    run_op("pre_rst", 3'd3, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    op = 3'd0; len = 1'b1; a = 32'h5; b = 32'h1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("mid_run_busy", busy, 1'b1);
    reset_n = 1'b0;
    step();
    check("mid_rst_busy",  busy,    1'b0);
    check("mid_rst_done",  done,    1'b0);
    check("mid_rst_o",     o,       32'h0);
    check("mid_rst_flags", flags(), 5'b00000);
    reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) dones++;
    end
    check("mid_rst_no_done", dones, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
